// File: rtl/debug_sequencer.sv
// Debug run sequencer: arms, runs and drains the hit generator while collecting TDC sample statistics.
// All outputs registered; optional RUN watchdog enabled by defining DEBUG_SEQ_WATCHDOG_EN.
module debug_sequencer #(
  parameter int CODE_W           = 8,
  parameter int CNT_W            = 16,
  parameter int ARM_CYCLES       = 4,
  parameter int DRAIN_CYCLES     = 512,
  parameter int EXPECTED_SAMPLES = 720,
  parameter int TIMEOUT_CYCLES   = 1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              dbg_finished,
  input  logic              tdc_valid,
  input  logic [CODE_W-1:0] tdc_code,
  output logic              dbg_rst,
  output logic              dbg_enable,
  output logic              hit_enable,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  sample_count,
  output logic [CODE_W-1:0] code_min,
  output logic [CODE_W-1:0] code_max
);

  localparam int PH_MAX = (ARM_CYCLES > DRAIN_CYCLES) ? ARM_CYCLES : DRAIN_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  ARM_LAST   = PH_W'(ARM_CYCLES - 1);
  localparam logic [PH_W-1:0]  DRAIN_LAST = PH_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;
  localparam logic [CNT_W-1:0] CNT_EXP    = CNT_W'(EXPECTED_SAMPLES);

  if (ARM_CYCLES < 1 || DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("debug_sequencer: ARM_CYCLES, DRAIN_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state, state_d;
  logic [PH_W-1:0]   ph_cnt, ph_cnt_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [CODE_W-1:0] min_d, max_d;
  logic              err_d;
  logic              smp_vld, smp_vld_d;
  logic [CODE_W-1:0] smp_code, smp_code_d;
  logic              count_en;
  logic              busy_d, dbg_rst_d, dbg_en_d, hit_en_d, done_d;

`ifdef DEBUG_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt, wd_cnt_d;

  // Counts RUN cycles only; any other state holds it at zero so RUN entry starts fresh.
  assign wd_cnt_d = (state == S_RUN) ? wd_cnt + WD_W'(1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d    = state;
    ph_cnt_d   = ph_cnt + PH_W'(1);
    cnt_d      = sample_count;
    min_d      = code_min;
    max_d      = code_max;
    err_d      = error;
    smp_vld_d  = 1'b0;
    smp_code_d = smp_code;
    count_en   = tdc_valid && ((state == S_RUN) || (state == S_DRAIN));

    // Second stage of the extreme tracker: compare the sample captured last cycle.
    if (smp_vld) begin
      if (smp_code < code_min) min_d = smp_code;
      if (smp_code > code_max) max_d = smp_code;
    end

    if (count_en) begin
      smp_vld_d  = 1'b1;
      smp_code_d = tdc_code;
      if (sample_count == CNT_SAT) begin
        err_d = 1'b1;
      end else begin
        cnt_d = sample_count + CNT_W'(1);
      end
    end

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_ARM;
          cnt_d   = '0;
          min_d   = '1;
          max_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_ARM: begin
        if (ph_cnt == ARM_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (dbg_finished) begin
          state_d = S_DRAIN;
        end
`ifdef DEBUG_SEQ_WATCHDOG_EN
        else if (wd_cnt == WD_LAST) begin
          state_d = S_DRAIN;
          err_d   = 1'b1;
        end
`endif
      end
      S_DRAIN: begin
        if (ph_cnt == DRAIN_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && ((state == S_ARM) || (state == S_RUN) || (state == S_DRAIN))) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end

    // Judge the run with the count that includes a sample on the final DRAIN cycle.
    if ((state_d == S_DONE) && (cnt_d != CNT_EXP)) err_d = 1'b1;

    if ((state_d != state) || (state_d == S_IDLE)) ph_cnt_d = '0;

    busy_d    = (state_d != S_IDLE);
    dbg_rst_d = (state_d == S_ARM) && (ph_cnt_d == '0);
    dbg_en_d  = ((state_d == S_ARM) && (ph_cnt_d != '0)) ||
                (state_d == S_RUN) || (state_d == S_DRAIN);
    hit_en_d  = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ph_cnt       <= '0;
      smp_vld      <= 1'b0;
      smp_code     <= '0;
      dbg_rst      <= 1'b0;
      dbg_enable   <= 1'b0;
      hit_enable   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      sample_count <= '0;
      code_min     <= '1;
      code_max     <= '0;
    end else begin
      state        <= state_d;
      ph_cnt       <= ph_cnt_d;
      smp_vld      <= smp_vld_d;
      smp_code     <= smp_code_d;
      dbg_rst      <= dbg_rst_d;
      dbg_enable   <= dbg_en_d;
      hit_enable   <= hit_en_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= err_d;
      sample_count <= cnt_d;
      code_min     <= min_d;
      code_max     <= max_d;
    end
  end

endmodule

// File: tb/tb_debug_sequencer.sv
// Randomized scoreboard bench for debug_sequencer; expected run results come from a sample-list model.
module tb_debug_sequencer;

  localparam int CODE_W   = 8;
  localparam int CNT_W    = 10;
  localparam int ARM_C    = 4;
  localparam int DRAIN_C  = 32;
  localparam int EXP_S    = 720;
  localparam int TMO      = 3000;
  localparam int SAT      = (1 << CNT_W) - 1;
  localparam int CODE_MAX = (1 << CODE_W) - 1;

  typedef struct {
    int cnt;
    int mn;
    int mx;
    int err;
    int done_cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              dbg_finished = 1'b0;
  logic              tdc_valid = 1'b0;
  logic [CODE_W-1:0] tdc_code = '0;
  logic              dbg_rst, dbg_enable, hit_enable, busy, done, error;
  logic [CNT_W-1:0]  sample_count;
  logic [CODE_W-1:0] code_min, code_max;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e_mon;
  logic prev_done = 1'b0;

  debug_sequencer #(
    .CODE_W(CODE_W), .CNT_W(CNT_W), .ARM_CYCLES(ARM_C), .DRAIN_CYCLES(DRAIN_C),
    .EXPECTED_SAMPLES(EXP_S), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dbg_finished(dbg_finished),
    .tdc_valid(tdc_valid), .tdc_code(tdc_code), .dbg_rst(dbg_rst), .dbg_enable(dbg_enable),
    .hit_enable(hit_enable), .busy(busy), .done(done), .error(error),
    .sample_count(sample_count), .code_min(code_min), .code_max(code_max)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_dbg_rst"}, dbg_rst, 0);
    chk({p, "_dbg_enable"}, dbg_enable, 0);
    chk({p, "_hit_enable"}, hit_enable, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_error"}, error, 0);
    chk({p, "_sample_count"}, sample_count, 0);
    chk({p, "_code_min"}, code_min, CODE_MAX);
    chk({p, "_code_max"}, code_max, 0);
  endtask

  // Run outcome from the list of samples the sequencer should have counted.
  function automatic exp_t model(input int codes[$], input int done_cyc);
    exp_t e;
    e.cnt = (codes.size() > SAT) ? SAT : codes.size();
    e.mn  = CODE_MAX;
    e.mx  = 0;
    foreach (codes[i]) begin
      if (codes[i] < e.mn) e.mn = codes[i];
      if (codes[i] > e.mx) e.mx = codes[i];
    end
    e.err      = ((codes.size() > SAT) || (e.cnt != EXP_S)) ? 1 : 0;
    e.done_cyc = done_cyc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_width", 32'(prev_done), 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 0);
      end else begin
        e_mon = sb.pop_front();
        chk("done_cycle", cyc, e_mon.done_cyc);
        chk("done_count", sample_count, e_mon.cnt);
        chk("done_min", code_min, e_mon.mn);
        chk("done_max", code_max, e_mon.mx);
        chk("done_error", error, e_mon.err);
      end
    end
    prev_done = done;
  end

  task automatic send(input int code);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    tdc_valid = 1'b1;
    tdc_code  = CODE_W'(code);
    @(negedge clk);
    tdc_valid = 1'b0;
  endtask

  // mode: 0 normal, 1 abort after wait_c RUN cycles, 2 reset in DRAIN, 3 watchdog, 4 noise in ARM/RUN
  task automatic run(input int n, input int lo, input int hi, input int mode, input int wait_c);
    int   codes[$];
    int   s, r, k, n_drain, n_run, pl, ph, bound;
    exp_t e;
    for (int i = 0; i < n; i++) codes.push_back(lo + int'($urandom_range(0, hi - lo)));
    if (n >= 2) begin
      pl = int'($urandom_range(0, n - 1));
      ph = (pl + 1 + int'($urandom_range(0, n - 2))) % n;
      codes[pl] = lo;
      codes[ph] = hi;
    end
    n_drain = (mode == 0 || mode == 2 || mode == 4) ? ((n < 5) ? n : 5) : 0;
    n_run   = n - n_drain;

    start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    chk("start_clears_count", sample_count, 0);
    chk("start_clears_error", error, 0);
    chk("start_clears_min", code_min, CODE_MAX);
    chk("start_clears_max", code_max, 0);
    chk("busy_in_arm", busy, 1);
    for (int i = 0; i < ARM_C; i++) begin
      chk("arm_dbg_rst", dbg_rst, (i == 0) ? 1 : 0);
      chk("arm_dbg_enable", dbg_enable, (i == 0) ? 0 : 1);
      chk("arm_hit_enable", hit_enable, 0);
      if (mode == 4) begin
        tdc_valid = 1'b1;
        tdc_code = '0;
        start = 1'b1;
        dbg_finished = 1'b1;
      end
      @(negedge clk);
    end
    tdc_valid = 1'b0;
    start = 1'b0;
    dbg_finished = 1'b0;
    r = cyc;
    chk("run_hit_enable", hit_enable, 1);
    chk("run_dbg_enable", dbg_enable, 1);
    chk("arm_ignores_samples", sample_count, 0);

    if (mode == 1) begin
      repeat (wait_c) @(negedge clk);
      chk("run_still_active", hit_enable, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_hit_enable", hit_enable, 0);
      chk("abort_dbg_enable", dbg_enable, 0);
      chk("abort_error", error, 1);
      chk("abort_done", done, 0);
      repeat (DRAIN_C + 8) @(negedge clk);
      chk("abort_stays_idle", busy, 0);
      return;
    end

    for (int i = 0; i < n_run; i++) begin
      if (mode == 4 && i == 5) start = 1'b1;
      send(codes[i]);
      start = 1'b0;
    end

    if (mode == 3) begin
      bound = 0;
      while (hit_enable && bound < TMO + 10) begin
        @(negedge clk);
        bound++;
      end
      chk("wd_drain_cycle", cyc, r + TMO);
      chk("wd_error", error, 1);
      chk("wd_dbg_enable", dbg_enable, 1);
      e = model(codes, r + TMO + DRAIN_C);
      e.err = 1;
      sb.push_back(e);
    end else begin
      dbg_finished = 1'b1;
      k = cyc + 1;
      @(negedge clk);
      dbg_finished = 1'b0;
      chk("drain_hit_enable", hit_enable, 0);
      chk("drain_dbg_enable", dbg_enable, 1);
      for (int i = 0; i < n_drain; i++) send(codes[n_run + i]);
      if (mode == 2) begin
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset("rst_in_drain");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      e = model(codes, k + DRAIN_C);
      sb.push_back(e);
    end

    bound = 0;
    while (sb.size() != 0 && bound < DRAIN_C + 40) begin
      @(negedge clk);
      bound++;
    end
    chk("done_seen", sb.size(), 0);
    @(negedge clk);
    chk("idle_after_done_busy", busy, 0);
    chk("idle_after_done_done", done, 0);
    tdc_valid = 1'b1;
    tdc_code  = '0;
    @(negedge clk);
    tdc_valid = 1'b0;
    @(negedge clk);
    chk("idle_hold_count", sample_count, e.cnt);
    chk("idle_hold_min", code_min, e.mn);
    chk("idle_hold_max", code_max, e.mx);
    chk("idle_hold_error", error, e.err);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;
    @(negedge clk);

    run(720, 3, 230, 0, 0);
    run(719, 3, 230, 0, 0);
    run(720, 10, 200, 4, 0);

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_with_abort_busy", busy, 0);
    chk("start_with_abort_hold", sample_count, 720);

    run(300, 0, CODE_MAX, 1, 10);
`ifdef DEBUG_SEQ_WATCHDOG_EN
    run(30, 20, 40, 3, 0);
`else
    run(30, 20, 40, 1, TMO + 100);
`endif
    run(720, 3, 230, 2, 0);
    run(720, 3, 230, 0, 0);
    run(1030, 0, CODE_MAX, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/debug_sequencer.md
DEBUG_SEQUENCER -- requirements
Module: debug_sequencer

Interface
REQ-001 SHALL have parameter CODE_W, default 8, width of TDC code.
REQ-002 SHALL have parameter CNT_W, default 16, width of sample counter.
REQ-003 SHALL have parameter ARM_CYCLES, default 4, cycles spent in ARM.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 512, cycles spent in DRAIN.
REQ-005 SHALL have parameter EXPECTED_SAMPLES, default 720 (3 passes x 240 taps), sample count required for a clean run.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1048576, RUN watchdog limit.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  one-cycle run request; honoured only in IDLE.
REQ-010 abort  in  1  level; terminates any active run.
REQ-011 dbg_finished  in  1  finished flag from debug hit generator.
REQ-012 tdc_valid  in  1  one-cycle pulse, TDC captured a code.
REQ-013 tdc_code  in  CODE_W  captured code, qualified by tdc_valid.
REQ-014 dbg_rst  out  1  synchronous reset to hit generator.
REQ-015 dbg_enable  out  1  whole-generator enable.
REQ-016 hit_enable  out  1  hit-emission enable.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 done  out  1  one-cycle pulse on run completion.
REQ-019 error  out  1  sticky run-failure flag.
REQ-020 sample_count  out  CNT_W  valid samples in current/last run.
REQ-021 code_min, code_max  out  CODE_W each  extreme codes seen in current/last run.

Function
REQ-022 SHALL implement states IDLE, ARM, RUN, DRAIN, DONE.
REQ-023 IDLE -> ARM on start with abort low; same edge clears sample_count to 0, code_min to all-ones, code_max to 0, error to 0.
REQ-024 ARM: dbg_rst high on first ARM cycle only; dbg_enable high from second ARM cycle; hit_enable low; -> RUN after exactly ARM_CYCLES cycles.
REQ-025 RUN: dbg_enable and hit_enable high; -> DRAIN on first cycle dbg_finished is sampled high.
REQ-026 DRAIN: dbg_enable high, hit_enable low; -> DONE after exactly DRAIN_CYCLES cycles.
REQ-027 DONE: lasts one cycle, done high; error set if sample_count != EXPECTED_SAMPLES; -> IDLE.
REQ-028 tdc_valid SHALL be counted in RUN and DRAIN only; ignored in IDLE, ARM, DONE.
REQ-029 Each counted sample SHALL update code_min/code_max with 1-cycle latency (registered compare).
REQ-030 sample_count SHALL saturate at 2^CNT_W-1, setting error; no wrap.
REQ-031 abort high in ARM, RUN or DRAIN -> IDLE next edge, error set, done not pulsed, dbg_enable/hit_enable low that edge.
REQ-032 abort and start same cycle in IDLE: start ignored.
REQ-033 start outside IDLE SHALL be ignored; dbg_finished outside RUN ignored.
REQ-034 sample_count, code_min, code_max, error SHALL hold their values in IDLE until next accepted start.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 rst asynchronously forces IDLE; dbg_rst, dbg_enable, hit_enable, busy, done, error = 0; sample_count = 0; code_min = all-ones; code_max = 0.
REQ-037 rst mid-run SHALL discard the run with no done pulse; first start after rst release SHALL be accepted normally.

Configuration
REQ-038 Macro DEBUG_SEQ_WATCHDOG_EN defined: RUN cycle counter; reaching TIMEOUT_CYCLES without dbg_finished -> DRAIN with error set; counter cleared on RUN entry.
REQ-039 Macro undefined: no watchdog logic; RUN waits indefinitely for dbg_finished or abort.

Verification
REQ-040 start, model finishes after 720 tdc_valid pulses, codes 3..230 -> done once, error 0, sample_count 720, code_min 3, code_max 230.
REQ-041 same run with only 719 samples -> done pulse, error 1, sample_count 719.
REQ-042 abort asserted 10 cycles into RUN -> IDLE next edge, no done, error 1, hit_enable low.
REQ-043 tdc_valid pulses in IDLE and ARM -> sample_count remains 0; second start while busy -> ignored, run timing unchanged.
REQ-044 DEBUG_SEQ_WATCHDOG_EN, TIMEOUT_CYCLES 100, dbg_finished held low -> DRAIN at RUN cycle 100, done after DRAIN_CYCLES, error 1.
REQ-045 rst pulsed during DRAIN -> all outputs at reset values immediately; subsequent start yields clean 720-sample run.
